arf_wb_commit: RTL and testbench

In-order writeback commit queue that drives the 4 write-back ports of the architectural register file (ARF).
- Accepts up to 2 completed results per cycle from the execute/retire lanes and buffers them in program order.
- Drains up to 4 results per cycle onto the ARF write ports, so that same-destination writes resolve youngest-wins and x0 stays zero.

---
 rtl/arf_wb_commit_if.sv | 46 ++++
 rtl/arf_wb_commit.sv | 114 +++++++++++
 tb/tb_arf_wb_commit.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/arf_wb_commit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// arf_wb_commit_if : result lanes, drain controls and ARF write-back ports
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
interface arf_wb_commit_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          drain_stall;
  logic          in_valid_0;
  logic [4:0]    in_rd_0;
  logic [63:0]   in_data_0;
  logic          in_valid_1;
  logic [4:0]    in_rd_1;
  logic [63:0]   in_data_1;
  logic          in_ready;
  logic [4:0]    wb_idex_0, wb_idex_1, wb_idex_2, wb_idex_3;
  logic [63:0]   wb_data_0, wb_data_1, wb_data_2, wb_data_3;
  logic          wb_en_0, wb_en_1, wb_en_2, wb_en_3;
  logic [CW-1:0] count;
  logic          empty;

  modport master (
    output flush, drain_stall,
    output in_valid_0, in_rd_0, in_data_0, in_valid_1, in_rd_1, in_data_1,
    input  in_ready,
    input  wb_idex_0, wb_idex_1, wb_idex_2, wb_idex_3,
    input  wb_data_0, wb_data_1, wb_data_2, wb_data_3,
    input  wb_en_0, wb_en_1, wb_en_2, wb_en_3,
    input  count, empty
  );

  modport slave (
    input  flush, drain_stall,
    input  in_valid_0, in_rd_0, in_data_0, in_valid_1, in_rd_1, in_data_1,
    output in_ready,
    output wb_idex_0, wb_idex_1, wb_idex_2, wb_idex_3,
    output wb_data_0, wb_data_1, wb_data_2, wb_data_3,
    output wb_en_0, wb_en_1, wb_en_2, wb_en_3,
    output count, empty
  );
endinterface
`default_nettype wire

// File: rtl/arf_wb_commit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// arf_wb_commit : in-order 2-in / up-to-4-out write-back commit queue
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
module arf_wb_commit #(
  parameter int DEPTH     = 8,
  parameter int DRAIN_MAX = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  arf_wb_commit_if.slave bus
);
  localparam int            AW          = $clog2(DEPTH);
  localparam int            CW          = AW + 1;
  localparam logic [CW-1:0] READY_LIMIT = CW'(DEPTH - 2);
  localparam logic [CW-1:0] DRAIN_LIMIT = CW'(DRAIN_MAX);

  logic [4:0]    slot_rd_q   [DEPTH];
  logic [63:0]   slot_data_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          in_ready;
  logic          wr0, wr1;
  logic [AW-1:0] wr1_slot;
  logic [CW-1:0] n_drain;
  logic [CW-1:0] n_enq;

  // Ready looks only at registered occupancy so it never depends on this cycle's drain.
  assign in_ready = (count_q <= READY_LIMIT);
  assign wr0      = in_ready && bus.in_valid_0 && !bus.flush;
  assign wr1      = in_ready && bus.in_valid_1 && !bus.flush;
  assign wr1_slot = wr_ptr_q + AW'(wr0);
  assign n_enq    = CW'(wr0) + CW'(wr1);
  assign n_drain  = bus.drain_stall ? '0 :
                    ((count_q > DRAIN_LIMIT) ? DRAIN_LIMIT : count_q);

  always_comb begin
    rd_ptr_d = rd_ptr_q + n_drain[AW-1:0];
    wr_ptr_d = wr_ptr_q + n_enq[AW-1:0];
    count_d  = count_q + n_enq - n_drain;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr0) begin
      slot_rd_q[wr_ptr_q]   <= bus.in_rd_0;
      slot_data_q[wr_ptr_q] <= bus.in_data_0;
    end
    if (wr1) begin
      slot_rd_q[wr1_slot]   <= bus.in_rd_1;
      slot_data_q[wr1_slot] <= bus.in_data_1;
    end
  end

  // Port p carries the p-th oldest entry; x0 targets and idle ports drive all-zero.
  for (genvar p = 0; p < 4; p++) begin : g_port
    logic [AW-1:0] slot;
    logic          take;
    logic          en_q;
    logic [4:0]    idex_q;
    logic [63:0]   data_q;

    assign slot = rd_ptr_q + AW'(p);
    assign take = !bus.flush && (CW'(p) < n_drain) && (slot_rd_q[slot] != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        en_q   <= 1'b0;
        idex_q <= 5'd0;
        data_q <= 64'd0;
      end else begin
        en_q   <= take;
        idex_q <= take ? slot_rd_q[slot] : 5'd0;
        data_q <= take ? slot_data_q[slot] : 64'd0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.count     = count_q;
  assign bus.empty     = (count_q == '0);
  assign bus.wb_en_0   = g_port[0].en_q;
  assign bus.wb_en_1   = g_port[1].en_q;
  assign bus.wb_en_2   = g_port[2].en_q;
  assign bus.wb_en_3   = g_port[3].en_q;
  assign bus.wb_idex_0 = g_port[0].idex_q;
  assign bus.wb_idex_1 = g_port[1].idex_q;
  assign bus.wb_idex_2 = g_port[2].idex_q;
  assign bus.wb_idex_3 = g_port[3].idex_q;
  assign bus.wb_data_0 = g_port[0].data_q;
  assign bus.wb_data_1 = g_port[1].data_q;
  assign bus.wb_data_2 = g_port[2].data_q;
  assign bus.wb_data_3 = g_port[3].data_q;
endmodule
`default_nettype wire

// File: tb/tb_arf_wb_commit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_arf_wb_commit : table vectors, directed corner sequences and a random run
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_arf_wb_commit;
  localparam int DEPTH     = 8;
  localparam int DRAIN_MAX = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  arf_wb_commit_if #(.DEPTH(DEPTH)) bus ();
  arf_wb_commit #(.DEPTH(DEPTH), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { logic [4:0] rd; logic [63:0] data; } entry_t;

  typedef struct {
    logic fl, st, v0; logic [4:0] r0; logic [63:0] d0;
    logic v1; logic [4:0] r1; logic [63:0] d1;
    int ecount; logic [3:0] een;
    logic [4:0] ei0; logic [63:0] ed0; logic [4:0] ei1; logic [63:0] ed1;
  } vec_t;

  entry_t      model_q[$];
  vec_t        vecs[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;

  logic [3:0]  dut_en;
  logic [4:0]  dut_idex [4];
  logic [63:0] dut_data [4];
  logic [3:0]  exp_en;
  logic [4:0]  exp_idex [4];
  logic [63:0] exp_data [4];

  always_comb begin
    dut_en      = {bus.wb_en_3, bus.wb_en_2, bus.wb_en_1, bus.wb_en_0};
    dut_idex[0] = bus.wb_idex_0; dut_idex[1] = bus.wb_idex_1;
    dut_idex[2] = bus.wb_idex_2; dut_idex[3] = bus.wb_idex_3;
    dut_data[0] = bus.wb_data_0; dut_data[1] = bus.wb_data_1;
    dut_data[2] = bus.wb_data_2; dut_data[3] = bus.wb_data_3;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic st,
                       input logic v0, input logic [4:0] r0, input logic [63:0] d0,
                       input logic v1, input logic [4:0] r1, input logic [63:0] d1);
    bus.flush = fl; bus.drain_stall = st;
    bus.in_valid_0 = v0; bus.in_rd_0 = r0; bus.in_data_0 = d0;
    bus.in_valid_1 = v1; bus.in_rd_1 = r1; bus.in_data_1 = d1;
  endtask

  // Reference: a FIFO of {rd,data}; each edge pops up to DRAIN_MAX oldest, then pushes accepted lanes.
  task automatic step();
    bit     rdy;
    int     n;
    entry_t e;
    rdy = (DEPTH - model_q.size()) >= 2;
    chk("in_ready", bus.in_ready, rdy);
    exp_en = 4'b0;
    for (int p = 0; p < 4; p++) begin exp_idex[p] = 5'd0; exp_data[p] = 64'd0; end
    if (bus.flush) begin
      model_q.delete();
    end else begin
      n = bus.drain_stall ? 0 : ((model_q.size() < DRAIN_MAX) ? model_q.size() : DRAIN_MAX);
      for (int p = 0; p < n; p++) begin
        e = model_q.pop_front();
        if (e.rd != 5'd0) begin exp_en[p] = 1'b1; exp_idex[p] = e.rd; exp_data[p] = e.data; end
      end
      if (rdy && bus.in_valid_0) begin e.rd = bus.in_rd_0; e.data = bus.in_data_0; model_q.push_back(e); end
      if (rdy && bus.in_valid_1) begin e.rd = bus.in_rd_1; e.data = bus.in_data_1; model_q.push_back(e); end
    end
    @(posedge clk); #1; cyc++;
    chk("count", bus.count, model_q.size());
    chk("empty", bus.empty, model_q.size() == 0);
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("wb_en_%0d", p), dut_en[p], exp_en[p]);
      chk($sformatf("wb_idex_%0d", p), dut_idex[p], exp_idex[p]);
      chk($sformatf("wb_data_%0d", p), dut_data[p], exp_data[p]);
    end
  endtask

  task automatic idle(input logic st);
    drive(1'b0, st, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    step();
  endtask

  task automatic pair(input logic st, input logic [4:0] r0, input logic [63:0] d0,
                      input logic [4:0] r1, input logic [63:0] d1);
    drive(1'b0, st, 1'b1, r0, d0, 1'b1, r1, d1);
    step();
  endtask

  function automatic vec_t mkv(input logic fl, input logic st,
                               input logic v0, input logic [4:0] r0, input logic [63:0] d0,
                               input logic v1, input logic [4:0] r1, input logic [63:0] d1,
                               input int ec, input logic [3:0] een,
                               input logic [4:0] ei0, input logic [63:0] ed0,
                               input logic [4:0] ei1, input logic [63:0] ed1);
    vec_t v;
    v.fl = fl; v.st = st; v.v0 = v0; v.r0 = r0; v.d0 = d0; v.v1 = v1; v.r1 = r1; v.d1 = d1;
    v.ecount = ec; v.een = een; v.ei0 = ei0; v.ed0 = ed0; v.ei1 = ei1; v.ed1 = ed1;
    return v;
  endfunction

  initial begin
    //                fl st v0 r0  d0       v1 r1  d1      cnt en       i0  d0     i1  d1
    vecs.push_back(mkv(0, 0, 1, 5, 'hA,     0, 0,  0,      1, 4'b0000, 0,  0,     0,  0));
    vecs.push_back(mkv(0, 0, 0, 0, 0,       0, 0,  0,      0, 4'b0001, 5,  'hA,   0,  0));
    vecs.push_back(mkv(0, 0, 0, 0, 0,       0, 0,  0,      0, 4'b0000, 0,  0,     0,  0));
    vecs.push_back(mkv(0, 0, 1, 7, 1,       1, 7,  2,      2, 4'b0000, 0,  0,     0,  0));
    vecs.push_back(mkv(0, 0, 0, 0, 0,       0, 0,  0,      0, 4'b0011, 7,  1,     7,  2));
    vecs.push_back(mkv(0, 0, 1, 0, 'hDEAD,  0, 0,  0,      1, 4'b0000, 0,  0,     0,  0));
    vecs.push_back(mkv(0, 0, 0, 0, 0,       0, 0,  0,      0, 4'b0000, 0,  0,     0,  0));
    vecs.push_back(mkv(0, 0, 0, 0, 0,       1, 9,  'h99,   1, 4'b0000, 0,  0,     0,  0));
    vecs.push_back(mkv(0, 0, 0, 0, 0,       0, 0,  0,      0, 4'b0001, 9,  'h99,  0,  0));
    vecs.push_back(mkv(0, 0, 1, 1, 'h11,    1, 2,  'h22,   2, 4'b0000, 0,  0,     0,  0));
    vecs.push_back(mkv(0, 0, 1, 3, 'h33,    1, 4,  'h44,   2, 4'b0011, 1,  'h11,  2,  'h22));
    vecs.push_back(mkv(0, 0, 1, 5, 'h55,    1, 6,  'h66,   2, 4'b0011, 3,  'h33,  4,  'h44));
    vecs.push_back(mkv(0, 0, 0, 0, 0,       0, 0,  0,      0, 4'b0011, 5,  'h55,  6,  'h66));
    vecs.push_back(mkv(0, 1, 1, 1, 'h11,    1, 2,  'h22,   2, 4'b0000, 0,  0,     0,  0));
    vecs.push_back(mkv(0, 1, 1, 3, 'h33,    1, 4,  'h44,   4, 4'b0000, 0,  0,     0,  0));
    vecs.push_back(mkv(0, 1, 1, 5, 'h55,    1, 6,  'h66,   6, 4'b0000, 0,  0,     0,  0));
    vecs.push_back(mkv(0, 0, 0, 0, 0,       0, 0,  0,      2, 4'b1111, 1,  'h11,  2,  'h22));
    vecs.push_back(mkv(0, 0, 0, 0, 0,       0, 0,  0,      0, 4'b0011, 5,  'h55,  6,  'h66));
    vecs.push_back(mkv(0, 1, 0, 0, 0,       0, 0,  0,      0, 4'b0000, 0,  0,     0,  0));
    vecs.push_back(mkv(0, 0, 1, 8, 'h88,    0, 0,  0,      1, 4'b0000, 0,  0,     0,  0));
    vecs.push_back(mkv(0, 1, 0, 0, 0,       0, 0,  0,      1, 4'b0000, 0,  0,     0,  0));
    vecs.push_back(mkv(0, 0, 0, 0, 0,       0, 0,  0,      0, 4'b0001, 8,  'h88,  0,  0));
    vecs.push_back(mkv(0, 1, 1, 10, 'hA0,   1, 11, 'hB0,   2, 4'b0000, 0,  0,     0,  0));
    vecs.push_back(mkv(1, 0, 1, 12, 'hC0,   1, 13, 'hD0,   0, 4'b0000, 0,  0,     0,  0));
    vecs.push_back(mkv(0, 0, 0, 0, 0,       0, 0,  0,      0, 4'b0000, 0,  0,     0,  0));

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_count", bus.count, 0);
    chk("reset_empty", bus.empty, 1);
    chk("reset_ready", bus.in_ready, 1);
    chk("reset_en", dut_en, 4'b0);
    chk("reset_idex0", dut_idex[0], 0);
    chk("reset_data0", dut_data[0], 0);

    foreach (vecs[i]) begin
      drive(vecs[i].fl, vecs[i].st, vecs[i].v0, vecs[i].r0, vecs[i].d0,
            vecs[i].v1, vecs[i].r1, vecs[i].d1);
      step();
      chk($sformatf("tbl%0d_count", i), bus.count, vecs[i].ecount);
      chk($sformatf("tbl%0d_en", i), dut_en, vecs[i].een);
      chk($sformatf("tbl%0d_idex0", i), dut_idex[0], vecs[i].ei0);
      chk($sformatf("tbl%0d_data0", i), dut_data[0], vecs[i].ed0);
      chk($sformatf("tbl%0d_idex1", i), dut_idex[1], vecs[i].ei1);
      chk($sformatf("tbl%0d_data1", i), dut_data[1], vecs[i].ed1);
    end

    // Fill to DEPTH-1 under stall: ready drops, extra inputs are dropped, release restores ready.
    pair(1'b1, 1, 'h101, 2, 'h102);
    pair(1'b1, 3, 'h103, 4, 'h104);
    pair(1'b1, 5, 'h105, 6, 'h106);
    drive(1'b0, 1'b1, 1'b1, 7, 'h107, 1'b0, 5'd0, 64'd0); step();
    chk("full_count7", bus.count, DEPTH - 1);
    chk("full_ready0", bus.in_ready, 0);
    pair(1'b1, 8, 'h108, 9, 'h109);
    chk("full_ignored", bus.count, DEPTH - 1);
    idle(1'b0);
    chk("release_count", bus.count, DEPTH - 1 - DRAIN_MAX);
    chk("release_ready", bus.in_ready, 1);
    chk("release_idex0", dut_idex[0], 1);
    chk("release_idex3", dut_idex[3], 4);
    idle(1'b0);
    chk("release_idex2", dut_idex[2], 7);

    // Flush at count=5 while enqueuing and not stalled.
    pair(1'b1, 1, 'h201, 2, 'h202);
    pair(1'b1, 3, 'h203, 4, 'h204);
    drive(1'b0, 1'b1, 1'b1, 5, 'h205, 1'b0, 5'd0, 64'd0); step();
    chk("pre_flush_count", bus.count, 5);
    drive(1'b1, 1'b0, 1'b1, 6, 'h206, 1'b1, 7, 'h207); step();
    chk("flush_count", bus.count, 0);
    chk("flush_empty", bus.empty, 1);
    chk("flush_en", dut_en, 4'b0);

    // Walk pointers to slot 6, then drain four entries straddling the wrap.
    pair(1'b1, 1, 'h301, 2, 'h302);
    pair(1'b1, 3, 'h303, 4, 'h304);
    pair(1'b1, 5, 'h305, 6, 'h306);
    idle(1'b0);
    idle(1'b0);
    pair(1'b1, 21, 'h321, 22, 'h322);
    pair(1'b1, 23, 'h323, 24, 'h324);
    idle(1'b0);
    chk("wrap_en", dut_en, 4'b1111);
    chk("wrap_idex0", dut_idex[0], 21);
    chk("wrap_idex1", dut_idex[1], 22);
    chk("wrap_idex2", dut_idex[2], 23);
    chk("wrap_data3", dut_data[3], 'h324);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom},
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom});
      step();
    end

    // Asynchronous reset away from a clock edge with entries pending.
    pair(1'b1, 1, 'h401, 2, 'h402);
    pair(1'b0, 3, 'h403, 4, 'h404);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_count", bus.count, 0);
    chk("async_rst_empty", bus.empty, 1);
    chk("async_rst_en", dut_en, 4'b0);
    chk("async_rst_data0", dut_data[0], 0);
    model_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
